sprite_line_fetcher: RTL
========================

SPRITE_LINE_FETCHER -- requirements
Module: sprite_line_fetcher

Interface
REQ-001 SHALL have parameter SPRITE_W, default 20, meaning sprite width in pixels.
REQ-002 SHALL have parameter SPRITE_H, default 20, meaning sprite height in rows; SPRITE_W*SPRITE_H SHALL be at most 1024.
REQ-003 SHALL have parameter TRANSPARENT, default 24'hFF00FF, meaning the colour key rendered as "no pixel".
REQ-004 Clk  in  1  single system/pixel clock; all logic on posedge Clk.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 line_start  in  1  one-cycle pulse at the start of horizontal blanking, before display line next_line.
REQ-007 next_line  in  10  DrawY of the upcoming display line; sampled when line_start=1.
REQ-008 sprite_x, sprite_y  in  10 each  top-left sprite position in screen pixels; sprite_y sampled on line_start, sprite_x used live.
REQ-009 DrawX  in  10  current horizontal pixel during active display.
REQ-010 rom_addr  out  10  read address to the sprite ROM; the ROM returns rom_data exactly 1 cycle after rom_addr is presented.
REQ-011 rom_data  in  24  RGB pixel from the sprite ROM.
REQ-012 pixel_on  out  1  sprite pixel is opaque at DrawX (registered).
REQ-013 pixel_rgb  out  24  sprite colour at DrawX; 0 when pixel_on=0 (registered).
REQ-014 busy  out  1  fetch in progress (state FETCH or DRAIN).

Function
REQ-015 FSM states SHALL be IDLE, FETCH, DRAIN, READY.
REQ-016 On line_start in any state: row = next_line - sprite_y (10-bit); hit SHALL be (next_line >= sprite_y) and (row < SPRITE_H), compared unsigned with no wrap.
REQ-017 line_start with hit SHALL load base = row*SPRITE_W, col = 0, clear line_valid, and enter FETCH next cycle.
REQ-018 line_start without hit SHALL clear line_valid and enter IDLE.
REQ-019 In FETCH, rom_addr SHALL equal base+col; col SHALL increment each cycle; after col = SPRITE_W-1 is issued, the FSM SHALL enter DRAIN.
REQ-020 rom_data arriving the cycle after address base+k is issued SHALL be written to line buffer entry k; in DRAIN, the final entry SPRITE_W-1 SHALL be written.
REQ-021 DRAIN SHALL last exactly 1 cycle, then enter READY with line_valid=1; total fetch SHALL take SPRITE_W+1 cycles from the first FETCH cycle.
REQ-022 line_start during FETCH or DRAIN SHALL abort the fetch and restart per REQ-016..018; a stale in-flight rom_data SHALL NOT be written after the abort.
REQ-023 In IDLE and READY, rom_addr SHALL hold its last value; no buffer writes SHALL occur.
REQ-024 Display path: dx = DrawX - sprite_x; in-range SHALL be (DrawX >= sprite_x) and (dx < SPRITE_W), no overflow for sprite_x near 1023.
REQ-025 Next-cycle pixel_on SHALL be line_valid and in-range and linebuf[dx] != TRANSPARENT; pixel_rgb SHALL be linebuf[dx] when pixel_on, else 0.
REQ-026 The display path SHALL have exactly 1 cycle latency from DrawX to pixel_on/pixel_rgb.
REQ-027 While line_valid=0, including during FETCH/DRAIN, pixel_on SHALL be 0.

Reset
REQ-028 Reset SHALL force state IDLE, line_valid=0, col=0, rom_addr=0, pixel_on=0, pixel_rgb=0, busy=0; line buffer contents need not be cleared.
REQ-029 Reset SHALL take priority over line_start in the same cycle; reset mid-fetch SHALL discard the fetch.

Verification
REQ-030 sprite_y=100, line_start with next_line=105 -> rom_addr 100..119 on 20 consecutive cycles, busy=1 for 21 cycles, then READY.
REQ-031 After REQ-030 with ROM model data = addr, sprite_x=300, DrawX=307 -> next cycle pixel_on=1, pixel_rgb=107; DrawX=320 -> pixel_on=0, pixel_rgb=0.
REQ-032 next_line=99 or next_line=120 with sprite_y=100 -> state IDLE, no rom_addr change, pixel_on=0 for all DrawX.
REQ-033 Entry k holds 24'hFF00FF -> pixel_on=0 at DrawX=sprite_x+k; neighbours stay opaque.
REQ-034 line_start pulse 10 cycles into a fetch (next_line=101) -> restart with rom_addr=20 next FETCH cycle; buffer holds row 1 only.
REQ-035 Reset asserted during FETCH and together with line_start -> all outputs 0, state IDLE next cycle.

Source files
------------

// File: rtl/sprite_line_fetcher.sv
// Purpose: prefetches one sprite row from ROM into a line buffer during blanking, then renders it at DrawX.
// Latency: fetch takes SPRITE_W+1 cycles from the first FETCH cycle; display path is 1 cycle DrawX -> pixel.
// Backpressure: none; a new line_start aborts any fetch in progress and restarts from the new line.
module sprite_line_fetcher #(
    parameter int          SPRITE_W    = 20,
    parameter int          SPRITE_H    = 20,
    parameter logic [23:0] TRANSPARENT = 24'hFF00FF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        line_start,
    input  logic [9:0]  next_line,
    input  logic [9:0]  sprite_x,
    input  logic [9:0]  sprite_y,
    input  logic [9:0]  DrawX,
    output logic [9:0]  rom_addr,
    input  logic [23:0] rom_data,
    output logic        pixel_on,
    output logic [23:0] pixel_rgb,
    output logic        busy
);

    localparam int IDX_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam logic [IDX_W-1:0] COL_LAST = IDX_W'(SPRITE_W - 1);
    localparam logic [9:0]  W10 = 10'(SPRITE_W);
    localparam logic [10:0] W11 = 11'(SPRITE_W);
    localparam logic [10:0] H11 = 11'(SPRITE_H);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        READY = 2'd3
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   col_q;
    logic [9:0]         rom_addr_q;
    logic               busy_q;
    logic               line_valid_q;
    // Write pipeline: the entry index that the ROM word arriving this cycle belongs to.
    logic               wr_vld_q;
    logic [IDX_W-1:0]   wr_idx_q;

    logic [23:0]        linebuf_q [SPRITE_W];

    logic               pixel_on_q;
    logic [23:0]        pixel_rgb_q;

    // Row hit test and base address for the upcoming line; unsigned, no wrap.
    logic [9:0]         row;
    logic               hit;
    logic [9:0]         base_new;

    // Display-path lookup for the current DrawX.
    logic [9:0]         dx;
    logic               in_range;
    logic [IDX_W-1:0]   rd_idx;
    logic [23:0]        pix;
    logic               opaque;

    // Row selection: hit only when the line lies within the sprite's vertical span.
    always_comb begin
        row      = next_line - sprite_y;
        hit      = (next_line >= sprite_y) && ({1'b0, row} < H11);
        base_new = row * W10;
    end

    // Fetch FSM: issues SPRITE_W consecutive addresses, drains the last ROM word, then marks the line valid.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            col_q        <= '0;
            rom_addr_q   <= '0;
            busy_q       <= 1'b0;
            line_valid_q <= 1'b0;
            wr_vld_q     <= 1'b0;
            wr_idx_q     <= '0;
        end else if (line_start) begin
            // Any outstanding ROM word belongs to the old line and must not land in the buffer.
            line_valid_q <= 1'b0;
            wr_vld_q     <= 1'b0;
            if (hit) begin
                state_q    <= FETCH;
                col_q      <= '0;
                rom_addr_q <= base_new;
                busy_q     <= 1'b1;
            end else begin
                state_q    <= IDLE;
                busy_q     <= 1'b0;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    wr_vld_q <= 1'b1;
                    wr_idx_q <= col_q;
                    if (col_q == COL_LAST) begin
                        state_q <= DRAIN;
                    end else begin
                        col_q      <= col_q + 1'b1;
                        rom_addr_q <= rom_addr_q + 10'd1;
                    end
                end
                DRAIN: begin
                    wr_vld_q     <= 1'b0;
                    state_q      <= READY;
                    busy_q       <= 1'b0;
                    line_valid_q <= 1'b1;
                end
                default: begin
                    wr_vld_q <= 1'b0;
                end
            endcase
        end
    end

    // Line buffer write: capture the ROM word one cycle after its address; suppressed on abort or reset.
    always_ff @(posedge Clk) begin
        if (wr_vld_q && !line_start && !Reset) begin
            linebuf_q[wr_idx_q] <= rom_data;
        end
    end

    // Horizontal hit test; the DrawX >= sprite_x term keeps a sprite near the right edge from wrapping.
    always_comb begin
        dx       = DrawX - sprite_x;
        in_range = (DrawX >= sprite_x) && ({1'b0, dx} < W11);
        rd_idx   = in_range ? dx[IDX_W-1:0] : '0;
        pix      = linebuf_q[rd_idx];
        opaque   = line_valid_q && in_range && (pix != TRANSPARENT);
    end

    // Registered pixel output: colour only when opaque, otherwise black.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pixel_on_q  <= 1'b0;
            pixel_rgb_q <= '0;
        end else begin
            pixel_on_q  <= opaque;
            pixel_rgb_q <= opaque ? pix : 24'h000000;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign busy      = busy_q;
    assign pixel_on  = pixel_on_q;
    assign pixel_rgb = pixel_rgb_q;

endmodule
